// File: rtl/mix_columns_iter.sv
// ---------------------------------------------------------------------------
// mix_columns_iter
//
// Iterative MixColumns / InvMixColumns engine for the redundant-representation
// datapath. A full state of NB columns is accepted in one handshake. Each
// column is then mixed in place, one column per clock, by a single shared 4x4
// matrix-multiply array. The mixed state is held until the consumer takes it.
//
// Every byte is an (8+d)-bit ring element. Index 0 of each element is its
// most significant bit. Multiplication by 2 in the ring is the bit matrix
// L_two. All other MDS coefficients are polynomials in L_two over GF(2), and
// they are built at elaboration.
//
// Parameters:
//   d      redundancy width; each byte is 8+d bits
//   L_two  (8+d)x(8+d) matrix for "times 2"; [r][c] = input bit c -> output bit r
//   NB     columns per state, 1..8
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   in_valid   input state valid
//   in_ready   engine idle and able to accept a state
//   inv_i      0 = MixColumns, 1 = InvMixColumns (captured on accept)
//   state_i    input state, [col][row][0:7+d]
//   out_valid  mixed state valid
//   out_ready  consumer takes the mixed state
//   state_o    mixed state, same layout as state_i (valid with out_valid)
//   busy_o     engine is mixing columns
// ---------------------------------------------------------------------------
module mix_columns_iter #(
    parameter int d = 4,
    parameter logic [0:7+d][0:7+d] L_two = '0,
    parameter int NB = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      inv_i,
    input  logic [NB-1:0][3:0][0:7+d] state_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NB-1:0][3:0][0:7+d] state_o,
    output logic                      busy_o
);

    localparam int W  = 8 + d;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef logic [0:W-1]          byte_t;
    typedef logic [0:W-1][0:W-1]   mat_t;
    typedef logic [3:0][0:W-1]     col_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic mat_t mat_identity();
        mat_t m;
        m = '0;
        for (int i = 0; i < W; i++) m[i][i] = 1'b1;
        return m;
    endfunction

    // GF(2) matrix product; these are only evaluated at elaboration.
    function automatic mat_t mat_mul(mat_t a, mat_t b);
        mat_t p;
        logic acc;
        p = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                acc = 1'b0;
                for (int k = 0; k < W; k++) acc = acc ^ (a[i][k] & b[k][j]);
                p[i][j] = acc;
            end
        end
        return p;
    endfunction

    // Output bit r is the parity of the input bits picked out by row r.
    function automatic byte_t mat_vec(mat_t m, byte_t v);
        byte_t o;
        o = '0;
        for (int r = 0; r < W; r++) o[r] = ^(m[r] & v);
        return o;
    endfunction

    localparam mat_t M_I  = mat_identity();
    localparam mat_t M_L  = L_two;
    localparam mat_t M_L2 = mat_mul(M_L, M_L);
    localparam mat_t M_L3 = mat_mul(M_L2, M_L);
    localparam mat_t M_2  = M_L;
    localparam mat_t M_3  = M_L ^ M_I;
    localparam mat_t M_9  = M_L3 ^ M_I;
    localparam mat_t M_11 = M_L3 ^ M_L ^ M_I;
    localparam mat_t M_13 = M_L3 ^ M_L2 ^ M_I;
    localparam mat_t M_14 = M_L3 ^ M_L2 ^ M_L;

    // Both MDS matrices are circulant, so the coefficient depends only on
    // k = (j - i) mod 4: forward {2,3,1,1}, inverse {14,11,13,9}.
    function automatic mat_t coef_sel(logic inv, logic [1:0] k);
        mat_t m;
        case ({inv, k})
            3'b000:  m = M_2;
            3'b001:  m = M_3;
            3'b010:  m = M_I;
            3'b011:  m = M_I;
            3'b100:  m = M_14;
            3'b101:  m = M_11;
            3'b110:  m = M_13;
            default: m = M_9;
        endcase
        return m;
    endfunction

    logic [1:0]                fsm;
    logic [CW-1:0]             col;
    logic                      inv_q;
    logic [NB-1:0][3:0][0:W-1] state_q;
    col_t                      cur_col;
    col_t                      mixed_col;
    byte_t                     acc;

    // The shared mixer: pick the current column, then form each output row
    // as the XOR of the four coefficient products.
    always_comb begin
        cur_col   = '0;
        mixed_col = '0;
        acc       = '0;
        for (int c = 0; c < NB; c++) begin
            if (col == CW'(c)) cur_col = state_q[c];
        end
        for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) begin
                acc = acc ^ mat_vec(coef_sel(inv_q, 2'(j - i)), cur_col[j]);
            end
            mixed_col[i] = acc;
        end
    end

    // Control and state register. The register is mixed in place, so no
    // second copy of the state is needed. In DONE the register is left alone
    // and in_valid is ignored until the consumer takes the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm     <= IDLE;
            col     <= '0;
            inv_q   <= 1'b0;
            state_q <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= state_i;
                        inv_q   <= inv_i;
                        col     <= '0;
                        fsm     <= BUSY;
                    end
                end
                BUSY: begin
                    for (int c = 0; c < NB; c++) begin
                        if (col == CW'(c)) state_q[c] <= mixed_col;
                    end
                    if (col == CW'(NB - 1)) begin
                        fsm <= DONE;
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy_o    = (fsm == BUSY);
    assign state_o   = state_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_iter
//
// Self-checking bench for mix_columns_iter. Four builds are exercised:
//   sel 0: d=0, NB=4, AES xtime matrix     (known answers, backpressure, reset)
//   sel 1: d=4, NB=4, x-times in GF(2)[x]/(P*Q)  (random states, round trips)
//   sel 2: d=0, NB=1                        (single column, latency 2)
//   sel 3: d=0, NB=8                        (replicated column, latency 9)
// The reference model works on ring elements as integers. "Times 2" is a
// shift with reduction by the ring modulus, and each coefficient is the sum
// of the shifted copies selected by its bits.
// ---------------------------------------------------------------------------
module tb_mix_columns_iter;

    typedef logic [255:0]          wide_t;
    typedef logic [7:0][3:0][15:0] st_t;

    // Build the "times x mod m" bit matrix in flattened form. Element index 0
    // is the MSB of the element, so integer bit k sits at index w-1-k.
    function automatic logic [143:0] mk_l(int w, int m);
        logic [143:0] f;
        int k;
        int j;
        f = '0;
        for (int r = 0; r < w; r++) begin
            for (int c = 0; c < w; c++) begin
                k = w - 1 - r;
                j = w - 1 - c;
                if ((j == k - 1) || ((j == w - 1) && (((m >> k) & 1) == 1)))
                    f[w*w - 1 - (r*w + c)] = 1'b1;
            end
        end
        return f;
    endfunction

    // 0x1B is the AES modulus minus x^8. 0x29D is the low part of
    // 0x11B * 0x13 = 0x129D (AES polynomial times x^4+x+1).
    localparam logic [143:0] L_AES = mk_l(8, 'h1B);
    localparam logic [143:0] L_RED = mk_l(12, 'h29D);

    int nb_of  [4] = '{4, 4, 1, 8};
    int w_of   [4] = '{8, 12, 8, 8};
    int mod_of [4] = '{'h1B, 'h29D, 'h1B, 'h1B};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid_v;
    logic [3:0] inv_v;
    logic [3:0] out_ready_v;
    wire  [3:0] in_ready_v;
    wire  [3:0] out_valid_v;
    wire  [3:0] busy_v;

    logic [127:0] sa_i;
    wire  [127:0] sa_o;
    logic [191:0] sb_i;
    wire  [191:0] sb_o;
    logic [31:0]  sc_i;
    wire  [31:0]  sc_o;
    logic [255:0] sd_i;
    wire  [255:0] sd_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mix_columns_iter #(.d(0), .L_two(L_AES[63:0]), .NB(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .inv_i(inv_v[0]), .state_i(sa_i), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .state_o(sa_o), .busy_o(busy_v[0]));

    mix_columns_iter #(.d(4), .L_two(L_RED[143:0]), .NB(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .inv_i(inv_v[1]), .state_i(sb_i), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .state_o(sb_o), .busy_o(busy_v[1]));

    mix_columns_iter #(.d(0), .L_two(L_AES[63:0]), .NB(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .inv_i(inv_v[2]), .state_i(sc_i), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .state_o(sc_o), .busy_o(busy_v[2]));

    mix_columns_iter #(.d(0), .L_two(L_AES[63:0]), .NB(8)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .inv_i(inv_v[3]), .state_i(sd_i), .out_valid(out_valid_v[3]),
        .out_ready(out_ready_v[3]), .state_o(sd_o), .busy_o(busy_v[3]));

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [15:0] xtime(logic [15:0] v, int w, int m);
        logic [15:0] mask;
        logic [15:0] r;
        mask = 16'((32'd1 << w) - 1);
        r = (v << 1) & mask;
        if (v[w-1]) r = r ^ 16'(m);
        return r;
    endfunction

    function automatic logic [15:0] ring_mul(int cf, logic [15:0] v, int w, int m);
        logic [15:0] acc;
        logic [15:0] p;
        acc = '0;
        p = v;
        for (int b = 0; b < 4; b++) begin
            if (((cf >> b) & 1) == 1) acc = acc ^ p;
            p = xtime(p, w, m);
        end
        return acc;
    endfunction

    function automatic st_t mix_model(st_t s, int nb, int w, int m, bit inv);
        int fw [4] = '{2, 3, 1, 1};
        int iv [4] = '{14, 11, 13, 9};
        st_t r;
        logic [15:0] acc;
        int cf;
        r = '0;
        for (int c = 0; c < nb; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) begin
                    cf = inv ? iv[(j - i + 4) % 4] : fw[(j - i + 4) % 4];
                    acc = acc ^ ring_mul(cf, s[c][j], w, m);
                end
                r[c][i] = acc;
            end
        end
        return r;
    endfunction

    // Element [col][row] occupies bits (col*4+row)*w upward; its integer
    // LSB is the lowest of those bits.
    function automatic wide_t pack(st_t s, int nb, int w);
        wide_t x;
        x = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                x = x | (wide_t'(s[c][r]) << ((c*4 + r) * w));
        return x;
    endfunction

    function automatic st_t unpack(wide_t x, int nb, int w);
        st_t s;
        wide_t mask;
        s = '0;
        mask = (wide_t'(1) << w) - wide_t'(1);
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                s[c][r] = 16'((x >> ((c*4 + r) * w)) & mask);
        return s;
    endfunction

    // Columns are 32-bit words, row 0 in the top byte, column 0 first.
    function automatic st_t kat_state(logic [127:0] v);
        st_t s;
        s = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[c][r] = {8'h00, v[127 - (c*32 + r*8) -: 8]};
        return s;
    endfunction

    function automatic st_t rand_state(int nb, int w);
        st_t s;
        s = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                s[c][r] = 16'($urandom_range(0, (1 << w) - 1));
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Checking and driving
    // ------------------------------------------------------------------
    task automatic checkOutput(input string tag, input wide_t got, input wide_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int sel, input wide_t x);
        case (sel)
            0:       sa_i = x[127:0];
            1:       sb_i = x[191:0];
            2:       sc_i = x[31:0];
            default: sd_i = x;
        endcase
    endtask

    function automatic wide_t get_out(int sel);
        case (sel)
            0:       return wide_t'(sa_o);
            1:       return wide_t'(sb_o);
            2:       return wide_t'(sc_o);
            default: return wide_t'(sd_o);
        endcase
    endfunction

    // One full transaction on build 'sel'. lat counts clock edges from the
    // accept edge (inclusive) to the edge after which out_valid is seen.
    task automatic applyStimulus(input int sel, input bit inv, input st_t st_in,
                                 input int stall, input bit toggle,
                                 output st_t st_out, output int lat, output int busy_cnt);
        wide_t win;
        wide_t got;
        int guard;
        win = pack(st_in, nb_of[sel], w_of[sel]);
        @(negedge clk);
        guard = 0;
        while (!in_ready_v[sel] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready_v[sel]) checkOutput("in_ready_timeout", wide_t'(in_ready_v[sel]), 1);
        in_valid_v[sel] = 1'b1;
        inv_v[sel]      = inv;
        set_in(sel, win);
        @(negedge clk);
        in_valid_v[sel] = 1'b0;
        lat = 1;
        busy_cnt = 0;
        if (toggle) begin
            inv_v[sel] = ~inv;
            set_in(sel, ~win);
        end
        while (!out_valid_v[sel] && lat < 40) begin
            if (busy_v[sel]) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!out_valid_v[sel]) checkOutput("out_valid_timeout", wide_t'(out_valid_v[sel]), 1);
        got = get_out(sel);
        for (int s = 0; s < stall; s++) begin
            in_valid_v[sel] = (s % 2 == 0);
            @(negedge clk);
            checkOutput("bp_stable", get_out(sel), got);
            checkOutput("bp_in_ready", wide_t'(in_ready_v[sel]), 0);
            checkOutput("bp_out_valid", wide_t'(out_valid_v[sel]), 1);
        end
        in_valid_v[sel]  = 1'b0;
        out_ready_v[sel] = 1'b1;
        @(negedge clk);
        out_ready_v[sel] = 1'b0;
        checkOutput("ready_after", wide_t'(in_ready_v[sel]), 1);
        st_out = unpack(got, nb_of[sel], w_of[sel]);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    st_t kin, kexp, res, back, rs, kd, ed;
    int  lat, bc;

    initial begin
        in_valid_v  = '0;
        inv_v       = '0;
        out_ready_v = '0;
        sa_i = '0; sb_i = '0; sc_i = '0; sd_i = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", wide_t'(in_ready_v[0]), 1);
        checkOutput("rst_out_valid", wide_t'(out_valid_v[0]), 0);
        checkOutput("rst_busy", wide_t'(busy_v[0]), 0);
        checkOutput("rst_state_o", wide_t'(sa_o), 0);
        for (int s = 1; s < 4; s++) checkOutput("rst_in_ready_other", wide_t'(in_ready_v[s]), 1);
        rst_n = 1'b1;

        kin  = kat_state(128'hdb135345_f20a225c_01010101_c6c6c6c6);
        kexp = kat_state(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);

        // Forward and inverse known answers
        applyStimulus(0, 1'b0, kin, 0, 1'b0, res, lat, bc);
        checkOutput("kat_fwd", pack(res, 4, 8), pack(kexp, 4, 8));
        checkOutput("kat_latency", wide_t'(lat), 5);
        checkOutput("kat_busy_cycles", wide_t'(bc), 4);
        applyStimulus(0, 1'b1, kexp, 0, 1'b0, res, lat, bc);
        checkOutput("kat_inv", pack(res, 4, 8), pack(kin, 4, 8));

        // Inputs changed after accept must not matter
        applyStimulus(0, 1'b0, kin, 0, 1'b1, res, lat, bc);
        checkOutput("toggle_fwd", pack(res, 4, 8), pack(kexp, 4, 8));
        applyStimulus(0, 1'b1, kexp, 0, 1'b1, res, lat, bc);
        checkOutput("toggle_inv", pack(res, 4, 8), pack(kin, 4, 8));

        // Backpressure: 10 stalled cycles in DONE
        applyStimulus(0, 1'b0, kin, 10, 1'b0, res, lat, bc);
        checkOutput("bp_result", pack(res, 4, 8), pack(kexp, 4, 8));

        // Reset during the second BUSY cycle
        @(negedge clk);
        in_valid_v[0] = 1'b1;
        inv_v[0] = 1'b0;
        set_in(0, pack(kin, 4, 8));
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        checkOutput("mid_busy", wide_t'(busy_v[0]), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_in_ready", wide_t'(in_ready_v[0]), 1);
        checkOutput("abort_out_valid", wide_t'(out_valid_v[0]), 0);
        checkOutput("abort_busy", wide_t'(busy_v[0]), 0);
        checkOutput("abort_state_o", wide_t'(sa_o), 0);
        applyStimulus(0, 1'b0, kin, 0, 1'b0, res, lat, bc);
        checkOutput("after_abort", pack(res, 4, 8), pack(kexp, 4, 8));

        // NB=1: first column only
        applyStimulus(2, 1'b0, kin, 0, 1'b0, res, lat, bc);
        checkOutput("nb1_result", pack(res, 1, 8), pack(kexp, 1, 8));
        checkOutput("nb1_latency", wide_t'(lat), 2);
        checkOutput("nb1_busy_cycles", wide_t'(bc), 1);

        // NB=8: first column replicated, then one random state
        kd = '0;
        ed = '0;
        for (int c = 0; c < 8; c++) begin
            kd[c] = kin[0];
            ed[c] = kexp[0];
        end
        applyStimulus(3, 1'b0, kd, 0, 1'b0, res, lat, bc);
        checkOutput("nb8_result", pack(res, 8, 8), pack(ed, 8, 8));
        checkOutput("nb8_latency", wide_t'(lat), 9);
        checkOutput("nb8_busy_cycles", wide_t'(bc), 8);
        rs = rand_state(8, 8);
        applyStimulus(3, 1'b1, rs, 0, 1'b0, res, lat, bc);
        checkOutput("nb8_rand_inv", pack(res, 8, 8), pack(mix_model(rs, 8, 8, 'h1B, 1'b1), 8, 8));

        // Redundant mode: random states against the model and round trips
        for (int n = 0; n < 1000; n++) begin
            rs = rand_state(4, 12);
            applyStimulus(1, 1'b0, rs, 0, 1'b0, res, lat, bc);
            checkOutput("red_fwd", pack(res, 4, 12), pack(mix_model(rs, 4, 12, 'h29D, 1'b0), 4, 12));
            applyStimulus(1, 1'b1, res, 0, 1'b0, back, lat, bc);
            checkOutput("red_roundtrip", pack(back, 4, 12), pack(rs, 4, 12));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
